tc_sram_stream: RTL and testbench



---
 rtl/tc_sram_stream.sv | 189 ++++++++++++++++++
 tb/tb_tc_sram_stream.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tc_sram_stream.sv
// tc_sram_stream
//   Multi-port behavioural SRAM with a valid/ready request handshake per
//   port, a Latency-deep read pipeline and a per-port response FIFO sized
//   by RspDepth. A per-port credit counter bounds the number of outstanding
//   reads, so the FIFO can never overflow and no push stall is needed.
//
// Handshake semantics: a request on port p transfers at a rising edge when
//   req_valid_i[p] & req_ready_o[p]. A response transfers at a rising edge
//   when rsp_valid_o[p] & rsp_ready_i[p]. While rsp_valid_o[p] is high,
//   rdata_o for that port stays stable until the transfer.
//
// Collision rules: same-edge read and write to one address are read-first.
//   Same-edge writes to one address resolve per byte lane, with the lowest
//   port index enabling that lane winning.
//
// Optional build macro: TC_SRAM_STREAM_COLL_CNT_EN enables the saturating
//   write-collision counter on coll_cnt_o; otherwise coll_cnt_o is 0.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_valid_i/req_ready_o request handshake, one bit per port
//   we_i, addr_i, wdata_i, be_i  request payload, packed per port
//   rsp_valid_o/rsp_ready_i read response handshake, one bit per port
//   rdata_o                 read response data, packed per port
//   coll_cnt_o              saturating count of overlapping-write edges
module tc_sram_stream #(
  parameter int unsigned NoWords   = 1024,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned NoPorts   = 2,
  parameter int unsigned Latency   = 1,
  parameter int unsigned RspDepth  = 4,
  parameter int unsigned AddrWidth = (NoWords > 1) ? $clog2(NoWords) : 1,
  parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NoPorts-1:0]             req_valid_i,
  output logic [NoPorts-1:0]             req_ready_o,
  input  logic [NoPorts-1:0]             we_i,
  input  logic [NoPorts*AddrWidth-1:0]   addr_i,
  input  logic [NoPorts*DataWidth-1:0]   wdata_i,
  input  logic [NoPorts*BeWidth-1:0]     be_i,
  output logic [NoPorts-1:0]             rsp_valid_o,
  input  logic [NoPorts-1:0]             rsp_ready_i,
  output logic [NoPorts*DataWidth-1:0]   rdata_o,
  output logic [15:0]                    coll_cnt_o
);

  localparam int unsigned StoreWidth = BeWidth * ByteWidth;
  localparam int unsigned CredWidth  = $clog2(RspDepth + 1);
  localparam int unsigned PtrWidth   = (RspDepth > 1) ? $clog2(RspDepth) : 1;

  if (NoPorts < 1 || NoPorts > 4 || Latency < 1 || Latency > 4 || RspDepth < Latency)
  begin : g_bad_param
    $fatal(1, "tc_sram_stream: illegal NoPorts/Latency/RspDepth");
  end

  // Storage is not reset, so it survives rst_i.
  logic [StoreWidth-1:0] mem_q [NoWords];

  logic [NoPorts-1:0][CredWidth-1:0]               credit_q, credit_d;
  logic [NoPorts-1:0][CredWidth-1:0]               count_q, count_d;
  logic [NoPorts-1:0][PtrWidth-1:0]                wptr_q, wptr_d, rptr_q, rptr_d;
  logic [NoPorts-1:0][Latency-1:0]                 pipe_vld_q, pipe_vld_d;
  logic [NoPorts-1:0][Latency-1:0][DataWidth-1:0]  pipe_data_q, pipe_data_d;
  logic [NoPorts-1:0][RspDepth-1:0][DataWidth-1:0] fifo_q, fifo_d;
  logic [NoPorts-1:0][StoreWidth-1:0]              wdata_pad;
  logic [NoPorts-1:0]                              rd_acc, wr_acc, pop, push;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
    if (ptr == PtrWidth'(RspDepth - 1)) return '0;
    return ptr + PtrWidth'(1);
  endfunction

  always_comb begin
    for (int p = 0; p < NoPorts; p++) begin
      req_ready_o[p] = (credit_q[p] != '0);
      rsp_valid_o[p] = (count_q[p] != '0);
      // FIFO entries are flops, so the head is a registered value.
      rdata_o[p*DataWidth +: DataWidth] = fifo_q[p][rptr_q[p]];
    end
  end

  always_comb begin
    credit_d    = credit_q;
    count_d     = count_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    pipe_vld_d  = pipe_vld_q;
    pipe_data_d = pipe_data_q;
    fifo_d      = fifo_q;
    rd_acc      = '0;
    wr_acc      = '0;
    pop         = '0;
    push        = '0;
    wdata_pad   = '0;
    for (int p = 0; p < NoPorts; p++) begin
      rd_acc[p]    = req_valid_i[p] & req_ready_o[p] & ~we_i[p];
      wr_acc[p]    = req_valid_i[p] & req_ready_o[p] & we_i[p];
      pop[p]       = rsp_valid_o[p] & rsp_ready_i[p];
      push[p]      = pipe_vld_q[p][Latency-1];
      wdata_pad[p] = StoreWidth'(wdata_i[p*DataWidth +: DataWidth]);

      // Reading mem_q before the edge gives read-first behaviour.
      pipe_vld_d[p][0]  = rd_acc[p];
      pipe_data_d[p][0] = mem_q[addr_i[p*AddrWidth +: AddrWidth]][DataWidth-1:0];
      for (int s = 1; s < Latency; s++) begin
        pipe_vld_d[p][s]  = pipe_vld_q[p][s-1];
        pipe_data_d[p][s] = pipe_data_q[p][s-1];
      end

      if (push[p]) begin
        fifo_d[p][wptr_q[p]] = pipe_data_q[p][Latency-1];
        wptr_d[p]            = ptr_inc(wptr_q[p]);
      end
      if (pop[p]) rptr_d[p] = ptr_inc(rptr_q[p]);

      if (push[p] && !pop[p])      count_d[p] = count_q[p] + CredWidth'(1);
      else if (pop[p] && !push[p]) count_d[p] = count_q[p] - CredWidth'(1);

      if (rd_acc[p] && !pop[p])      credit_d[p] = credit_q[p] - CredWidth'(1);
      else if (pop[p] && !rd_acc[p]) credit_d[p] = credit_q[p] + CredWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < NoPorts; p++) credit_q[p] <= CredWidth'(RspDepth);
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      pipe_vld_q  <= '0;
      pipe_data_q <= '0;
      fifo_q      <= '0;
    end else begin
      credit_q    <= credit_d;
      count_q     <= count_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_data_q <= pipe_data_d;
      fifo_q      <= fifo_d;
    end
  end

  // Ports are visited from highest to lowest index; the later assignment
  // of a lane wins, giving the lowest enabled port priority per lane.
  always_ff @(posedge clk_i) begin
    for (int p = NoPorts - 1; p >= 0; p--) begin
      if (wr_acc[p]) begin
        for (int l = 0; l < BeWidth; l++) begin
          if (be_i[p*BeWidth + l])
            mem_q[addr_i[p*AddrWidth +: AddrWidth]][l*ByteWidth +: ByteWidth]
              <= wdata_pad[p][l*ByteWidth +: ByteWidth];
        end
      end
    end
  end

`ifdef TC_SRAM_STREAM_COLL_CNT_EN
  logic [15:0] coll_cnt_q, coll_cnt_d;
  logic        coll_hit;

  always_comb begin
    coll_hit = 1'b0;
    for (int p = 0; p < NoPorts; p++) begin
      for (int q = p + 1; q < NoPorts; q++) begin
        if (wr_acc[p] && wr_acc[q] &&
            addr_i[p*AddrWidth +: AddrWidth] == addr_i[q*AddrWidth +: AddrWidth] &&
            |(be_i[p*BeWidth +: BeWidth] & be_i[q*BeWidth +: BeWidth]))
          coll_hit = 1'b1;
      end
    end
    coll_cnt_d = coll_cnt_q;
    if (coll_hit && coll_cnt_q != 16'hFFFF) coll_cnt_d = coll_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) coll_cnt_q <= '0;
    else       coll_cnt_q <= coll_cnt_d;
  end

  assign coll_cnt_o = coll_cnt_q;
`else
  assign coll_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tc_sram_stream.sv
// Directed bench for tc_sram_stream: 3 ports, Latency 2, RspDepth 4,
// 16 words of 64 bits.
module tb_tc_sram_stream;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req_valid, req_ready, we, rsp_valid, rsp_ready;
  logic [11:0]   addr;
  logic [191:0]  wdata, rdata;
  logic [23:0]   be;
  logic [15:0]   coll_cnt;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int acc;
  logic [63:0] exp_q[$];
  logic [63:0] exp_coll;

  localparam logic [63:0] DEAD = 64'hDEADBEEF_01234567;

  tc_sram_stream #(
    .NoWords(16), .DataWidth(64), .ByteWidth(8), .NoPorts(3),
    .Latency(2), .RspDepth(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rdata_o(rdata), .coll_cnt_o(coll_cnt)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic w, input logic [3:0] a,
                         input logic [63:0] d, input logic [7:0] b);
    req_valid[p]     = 1'b1;
    we[p]            = w;
    addr[p*4 +: 4]   = a;
    wdata[p*64 +: 64] = d;
    be[p*8 +: 8]     = b;
  endtask

  task automatic clr_req();
    req_valid = '0;
  endtask

  function automatic logic [63:0] rd(input int p);
    return rdata[p*64 +: 64];
  endfunction

  function automatic logic [63:0] dval(input int a);
    return 64'hC0DE_0000_0000_0000 | 64'(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
`ifdef TC_SRAM_STREAM_COLL_CNT_EN
    exp_coll = 64'd1;
`else
    exp_coll = 64'd0;
`endif
    rst = 1'b1; req_valid = '0; we = '0; addr = '0; wdata = '0; be = '0;
    rsp_ready = '0;
    #2;
    chk("rst_ready", 64'(req_ready), 64'h7);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rdata0", rd(0), 64'h0);
    chk("rst_rdata2", rd(2), 64'h0);
    chk("rst_coll", 64'(coll_cnt), 64'h0);
    cycle(); cycle();
    rst = 1'b0;

    // Write then read-back latency on port 0.
    set_req(0, 1'b1, 4'd5, DEAD, 8'hFF); cycle(); clr_req();
    set_req(0, 1'b0, 4'd5, 64'h0, 8'h00); cycle(); clr_req();
    chk("lat_k0_valid", 64'(rsp_valid[0]), 64'h0);
    cycle();
    chk("lat_k1_valid", 64'(rsp_valid[0]), 64'h0);
    cycle();
    chk("lat_k2_valid", 64'(rsp_valid[0]), 64'h1);
    chk("lat_k2_data", rd(0), DEAD);
    cycle();
    chk("hold_valid", 64'(rsp_valid[0]), 64'h1);
    chk("hold_data", rd(0), DEAD);
    rsp_ready[0] = 1'b1; cycle(); rsp_ready[0] = 1'b0;
    chk("pop_empty", 64'(rsp_valid[0]), 64'h0);

    // Byte enables on port 1.
    set_req(1, 1'b1, 4'd3, 64'h1111_1111_1111_1111, 8'hFF); cycle();
    set_req(1, 1'b1, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F); cycle();
    set_req(1, 1'b0, 4'd3, 64'h0, 8'h00); rsp_ready[1] = 1'b1; cycle(); clr_req();
    cycle(); cycle();
    chk("be_valid", 64'(rsp_valid[1]), 64'h1);
    chk("be_data", rd(1), 64'h11111111_FFFFFFFF);
    cycle();

    // Backpressure: six read attempts with no response ready.
    for (int i = 0; i < 5; i++) begin
      set_req(2, 1'b1, 4'(8 + i), dval(8 + i), 8'hFF); cycle();
    end
    clr_req();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) chk("bp_ready_drop", 64'(req_ready[0]), 64'h0);
      set_req(0, 1'b0, 4'(8 + acc), 64'h0, 8'h00);
      if (req_ready[0]) begin
        exp_q.push_back(dval(8 + acc));
        acc++;
      end
      cycle();
    end
    clr_req();
    chk("bp_accepted", 64'(acc), 64'd4);
    chk("bp_ready_low", 64'(req_ready[0]), 64'h0);
    cycle();
    rsp_ready[0] = 1'b1;
    while (exp_q.size() > 0) begin
      chk("bp_rsp_valid", 64'(rsp_valid[0]), 64'h1);
      chk("bp_rsp_data", rd(0), exp_q.pop_front());
      cycle();
    end
    rsp_ready[0] = 1'b0;
    chk("bp_drained", 64'(rsp_valid[0]), 64'h0);
    chk("bp_ready_back", 64'(req_ready[0]), 64'h1);

    // Cross-port collision on address 7 with a same-edge read on port 2.
    set_req(0, 1'b1, 4'd7, 64'h0, 8'hFF); cycle(); clr_req();
    set_req(0, 1'b1, 4'd7, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
    set_req(1, 1'b1, 4'd7, 64'h5555_5555_5555_5555, 8'hF0);
    set_req(2, 1'b0, 4'd7, 64'h0, 8'h00);
    cycle(); clr_req();
    chk("coll_cnt", 64'(coll_cnt), exp_coll);
    cycle(); cycle();
    chk("coll_rd_valid", 64'(rsp_valid[2]), 64'h1);
    chk("coll_rd_first", rd(2), 64'h0);
    rsp_ready[2] = 1'b1; cycle();
    set_req(2, 1'b0, 4'd7, 64'h0, 8'h00); cycle(); clr_req();
    cycle(); cycle();
    chk("coll_winner", rd(2), 64'hAAAA_AAAA_AAAA_AAAA);
    cycle();

    // Same-edge writes to address 6 with disjoint lanes: no collision.
    set_req(0, 1'b1, 4'd6, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    set_req(1, 1'b1, 4'd6, 64'h5555_5555_5555_5555, 8'hF0);
    cycle(); clr_req();
    chk("nocoll_cnt", 64'(coll_cnt), exp_coll);
    set_req(2, 1'b0, 4'd6, 64'h0, 8'h00); cycle(); clr_req();
    cycle(); cycle();
    chk("nocoll_data", rd(2), 64'h55555555_AAAAAAAA);
    cycle();
    rsp_ready[2] = 1'b0;

    // Reset while a read is in flight.
    rsp_ready[0] = 1'b1;
    set_req(0, 1'b0, 4'd5, 64'h0, 8'h00); cycle(); clr_req();
    cycle();
    rst = 1'b1; #1;
    chk("midrst_valid", 64'(rsp_valid), 64'h0);
    chk("midrst_ready", 64'(req_ready), 64'h7);
    chk("midrst_coll", 64'(coll_cnt), 64'h0);
    cycle(); cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("midrst_no_rsp", 64'(rsp_valid[0]), 64'h0);
      cycle();
    end
    rsp_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("midrst_credit", 64'(req_ready[0]), 64'h1);
      set_req(0, 1'b0, 4'd5, 64'h0, 8'h00); cycle();
    end
    clr_req();
    chk("midrst_exhaust", 64'(req_ready[0]), 64'h0);
    cycle(); cycle();
    rsp_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("midrst_data", rd(0), DEAD);
      cycle();
    end
    chk("final_empty", 64'(rsp_valid[0]), 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
